// File: rtl/pattern_sequencer_multichannel_if.sv
// Shared pattern-RAM write port and window configuration bus for
// pattern_sequencer_multichannel. The command side drives the master modport;
// the sequencer consumes the slave modport.
interface pattern_sequencer_multichannel_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_DEPTH      = 11,
    parameter int NUMBER_OF_CHANNELS = 4,
    parameter int REPEAT_WIDTH       = 16
);
    localparam int CHANNEL_WIDTH = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1;

    logic                     write_enable;
    logic [CHANNEL_WIDTH-1:0] write_channel;
    logic [ADDRESS_DEPTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;

    logic                     config_strobe;
    logic [CHANNEL_WIDTH-1:0] config_channel;
    logic [ADDRESS_DEPTH-1:0] start_address;
    logic [ADDRESS_DEPTH-1:0] end_address;
    logic [REPEAT_WIDTH-1:0]  repeat_count;

    modport master (
        output write_enable,
        output write_channel,
        output write_address,
        output write_data,
        output config_strobe,
        output config_channel,
        output start_address,
        output end_address,
        output repeat_count
    );

    modport slave (
        input write_enable,
        input write_channel,
        input write_address,
        input write_data,
        input config_strobe,
        input config_channel,
        input start_address,
        input end_address,
        input repeat_count
    );
endinterface

// File: rtl/pattern_sequencer_multichannel.sv
// N-channel pattern playback engine. Each channel owns a read-first pattern
// RAM and replays the window [start, end) into its oserdes data lane, with
// arm/trigger, finite repeat counts, shadowed window registers that take
// effect only at pass boundaries, and per-channel done / sync markers.
// Optional build macro PATTERN_SEQUENCER_IDLE_HOLD_EN: when defined, data_out
// holds the last presented word while a channel sits in IDLE or ARMED;
// otherwise data_out is 0 whenever the channel is not running.
module pattern_sequencer_multichannel #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_DEPTH      = 11,
    parameter int NUMBER_OF_CHANNELS = 4,
    parameter int REPEAT_WIDTH       = 16,
    parameter int SYNC_OUT_DELAY     = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    pattern_sequencer_multichannel_if.slave          bus,
    input  logic [NUMBER_OF_CHANNELS-1:0]            i_arm,
    input  logic [NUMBER_OF_CHANNELS-1:0]            i_abort,
    input  logic                                     i_sync_in,
    output logic [NUMBER_OF_CHANNELS*DATA_WIDTH-1:0] o_data_out,
    output logic [NUMBER_OF_CHANNELS-1:0]            o_running,
    output logic [NUMBER_OF_CHANNELS-1:0]            o_done,
    output logic [NUMBER_OF_CHANNELS-1:0]            o_sync_out
);
    localparam int CHANNEL_WIDTH = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1;
    localparam int RAM_WORDS     = 1 << ADDRESS_DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } channelState_t;

    for (genvar gCh = 0; gCh < NUMBER_OF_CHANNELS; gCh++) begin : gChannel
        logic [DATA_WIDTH-1:0]    r_patternRam [RAM_WORDS];
        channelState_t            r_state;
        logic [ADDRESS_DEPTH-1:0] r_readAddress;
        logic [ADDRESS_DEPTH-1:0] r_activeStart;
        logic [ADDRESS_DEPTH-1:0] r_activeEnd;
        logic [REPEAT_WIDTH-1:0]  r_activeRepeat;
        logic [ADDRESS_DEPTH-1:0] r_shadowStart;
        logic [ADDRESS_DEPTH-1:0] r_shadowEnd;
        logic [REPEAT_WIDTH-1:0]  r_shadowRepeat;
        logic [REPEAT_WIDTH-1:0]  r_passCount;
        logic [DATA_WIDTH-1:0]    r_dataOut;
        logic                     r_done;
        logic                     r_startMarker;

        logic [DATA_WIDTH-1:0]    w_readWord;
        logic [ADDRESS_DEPTH-1:0] w_endMinusOne;
        logic                     w_writeHit;
        logic                     w_configHit;
        logic                     w_lastAddress;
        logic                     w_finalPass;
        logic                     w_abort;
        logic                     w_arm;

        assign w_writeHit    = bus.write_enable  && (bus.write_channel  == CHANNEL_WIDTH'(gCh));
        assign w_configHit   = bus.config_strobe && (bus.config_channel == CHANNEL_WIDTH'(gCh));
        assign w_abort       = i_abort[gCh];
        assign w_arm         = i_arm[gCh];
        assign w_endMinusOne = r_activeEnd - ADDRESS_DEPTH'(1);
        assign w_lastAddress = (r_readAddress == w_endMinusOne);
        assign w_finalPass   = (r_activeRepeat != '0) && (r_passCount == r_activeRepeat);

        // Asynchronous read is sampled by r_dataOut on the same edge as the
        // write, so a colliding write returns the old word (read-first).
        assign w_readWord = r_patternRam[r_readAddress];

        // Pattern RAM write port; contents deliberately survive reset.
        always_ff @(posedge clock) begin
            if (w_writeHit) begin
                r_patternRam[bus.write_address] <= bus.write_data;
            end
        end

        // Channel FSM: shadow capture, window playback, pass counting and output registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state        <= IDLE;
                r_readAddress  <= '0;
                r_activeStart  <= '0;
                r_activeEnd    <= '0;
                r_activeRepeat <= '0;
                r_shadowStart  <= '0;
                r_shadowEnd    <= '0;
                r_shadowRepeat <= '0;
                r_passCount    <= '0;
                r_dataOut      <= '0;
                r_done         <= 1'b0;
                r_startMarker  <= 1'b0;
            end else begin
                r_done        <= 1'b0;
                r_startMarker <= 1'b0;

                if (w_configHit) begin
                    r_shadowStart  <= bus.start_address;
                    r_shadowEnd    <= bus.end_address;
                    r_shadowRepeat <= bus.repeat_count;
                end

                if ((r_state == RUN) && !w_abort) begin
                    r_dataOut <= w_readWord;
                end else begin
`ifdef PATTERN_SEQUENCER_IDLE_HOLD_EN
                    r_dataOut <= r_dataOut;
`else
                    r_dataOut <= '0;
`endif
                end

                case (r_state)
                    IDLE: begin
                        if (!w_abort && w_arm) begin
                            r_state <= ARMED;
                        end
                    end

                    ARMED: begin
                        if (w_abort) begin
                            r_state <= IDLE;
                        end else if (i_sync_in) begin
                            r_state        <= RUN;
                            r_activeStart  <= r_shadowStart;
                            r_activeEnd    <= r_shadowEnd;
                            r_activeRepeat <= r_shadowRepeat;
                            r_readAddress  <= r_shadowStart;
                            r_passCount    <= REPEAT_WIDTH'(1);
                            r_startMarker  <= 1'b1;
                        end
                    end

                    RUN: begin
                        if (w_abort) begin
                            r_state <= IDLE;
                        end else if (i_sync_in) begin
                            r_activeStart  <= r_shadowStart;
                            r_activeEnd    <= r_shadowEnd;
                            r_activeRepeat <= r_shadowRepeat;
                            r_readAddress  <= r_shadowStart;
                            r_passCount    <= REPEAT_WIDTH'(1);
                            r_startMarker  <= 1'b1;
                        end else if (w_lastAddress) begin
                            r_activeStart  <= r_shadowStart;
                            r_activeEnd    <= r_shadowEnd;
                            r_activeRepeat <= r_shadowRepeat;
                            if (w_finalPass) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_readAddress <= r_shadowStart;
                                r_startMarker <= 1'b1;
                                if (r_passCount != {REPEAT_WIDTH{1'b1}}) begin
                                    r_passCount <= r_passCount + REPEAT_WIDTH'(1);
                                end
                            end
                        end else begin
                            r_readAddress <= r_readAddress + ADDRESS_DEPTH'(1);
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end

        if (SYNC_OUT_DELAY == 0) begin : gSyncDirect
            assign o_sync_out[gCh] = r_startMarker;
        end else begin : gSyncDelay
            logic [SYNC_OUT_DELAY-1:0] r_syncDelay;

            // Delay line that lines the pass-start marker up with the data lane.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_syncDelay <= '0;
                end else begin
                    r_syncDelay <= (r_syncDelay << 1) | SYNC_OUT_DELAY'(r_startMarker);
                end
            end

            assign o_sync_out[gCh] = r_syncDelay[SYNC_OUT_DELAY-1];
        end

        assign o_data_out[gCh*DATA_WIDTH +: DATA_WIDTH] = r_dataOut;
        assign o_running[gCh]                           = (r_state == RUN);
        assign o_done[gCh]                              = r_done;
    end
endmodule
